// File: rtl/bridge_controller_multi.sv
// bridge_controller_multi: UART command decoder driving SPI configuration, N chip selects
// and single, burst or fill-read SPI transfers, each result returned over UART.
module bridge_controller_multi #(
   parameter int         NUM_CS           = 4,
   parameter int         DEFAULT_BAUD_DIV = 433,
   parameter logic [7:0] FILL_BYTE        = 8'hFF
) (
   input  logic              clk,
   input  logic              rst,
   output logic [7:0]        spi_clk_div,
   output logic              cpol,
   output logic              cpha,
   output logic              transfer_req,
   input  logic              transfer_ready,
   input  logic              transfer_done,
   output logic [7:0]        to_agent,
   input  logic [7:0]        from_agent,
   output logic [15:0]       uart_clk_div,
   output logic              tx_req,
   output logic [7:0]        tx_data,
   input  logic [7:0]        rx_data,
   input  logic              tx_ready,
   input  logic              rx_ready,
   output logic [NUM_CS-1:0] cs_n,
   output logic [7:0]        led,
   output logic [15:0]       hex_data
);
   typedef enum logic [3:0] {
      S_IDLE, S_ARG, S_BAUD_L, S_BAUD_H, S_LEN, S_GET, S_SRQ, S_SGT, S_URQ, S_STAT
   } state_t;
   state_t            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d, cnt_q, cnt_d, lo_q, lo_d;
   logic              rd_q, rd_d, stat_q, stat_d;
   logic [7:0]        spi_div_q, spi_div_d, to_agent_q, to_agent_d, tx_data_q, tx_data_d;
   logic              cpol_q, cpol_d, cpha_q, cpha_d, treq_q, treq_d, txreq_q, txreq_d;
   logic [15:0]       baud_q, baud_d, hex_q, hex_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d, cs_sel;
   logic [7:0]        cmd_cnt_q, cmd_cnt_d, err_q, err_d, err_inc, xbyte;
   logic              cs_ok, start;
   assign err_inc = err_q + {7'd0, err_q != 8'hFF};
   assign cs_ok   = 32'(rx_data[6:0]) < NUM_CS;
   assign cs_sel  = ~(NUM_CS'(1) << rx_data[6:0]);
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      cnt_d      = cnt_q;
      lo_d       = lo_q;
      rd_d       = rd_q;
      stat_d     = stat_q;
      spi_div_d  = spi_div_q;
      to_agent_d = to_agent_q;
      tx_data_d  = tx_data_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      treq_d     = treq_q;
      txreq_d    = txreq_q;
      baud_d     = baud_q;
      hex_d      = hex_q;
      cs_n_d     = cs_n_q;
      cmd_cnt_d  = cmd_cnt_q;
      err_d      = err_q;
      start      = 1'b0;
      xbyte      = rx_data;
      case (state_q)
         S_IDLE: if (rx_ready) begin
            cmd_cnt_d = cmd_cnt_q + 8'd1;
            cmd_d     = rx_data;
            cnt_d     = 8'd0;
            rd_d      = rx_data == 8'h08;
            case (rx_data)
               8'h00: ;
               8'h01, 8'h02, 8'h03, 8'h05, 8'h06: state_d = S_ARG;
               8'h04: state_d = S_BAUD_L;
               8'h07, 8'h08: state_d = S_LEN;
               8'h09: begin
                  tx_data_d = cmd_cnt_q + 8'd1;
                  txreq_d   = 1'b1;
                  stat_d    = 1'b1;
                  state_d   = S_URQ;
               end
               default: err_d = err_inc;
            endcase
         end
         S_ARG: if (rx_ready) begin
            state_d = S_IDLE;
            case (cmd_q)
               8'h01: begin
                  tx_data_d = rx_data;
                  txreq_d   = 1'b1;
                  state_d   = S_URQ;
               end
               8'h02: spi_div_d = rx_data;
               8'h03: begin
                  cpha_d = rx_data[0];
                  cpol_d = rx_data[1];
               end
               8'h05: begin
                  cs_n_d = (rx_data[7] && cs_ok) ? cs_sel : '1;
                  err_d  = (rx_data[7] && !cs_ok) ? err_inc : err_q;
               end
               default: start = 1'b1;
            endcase
         end
         S_BAUD_L: if (rx_ready) begin
            lo_d    = rx_data;
            state_d = S_BAUD_H;
         end
         S_BAUD_H: if (rx_ready) begin
            baud_d  = {rx_data, lo_q};
            state_d = S_IDLE;
         end
         S_LEN: if (rx_ready) begin
            cnt_d   = rx_data;
            state_d = S_GET;
            start   = rd_q;
            xbyte   = FILL_BYTE;
         end
         S_GET: start = rx_ready;
         S_SRQ: if (transfer_ready) begin
            treq_d  = 1'b0;
            state_d = S_SGT;
         end
         S_SGT: if (transfer_done) begin
            tx_data_d = from_agent;
            hex_d     = {hex_q[15:8], from_agent};
            txreq_d   = 1'b1;
            state_d   = S_URQ;
         end
         S_URQ: if (tx_ready) begin
            txreq_d = 1'b0;
            state_d = S_IDLE;
            if (stat_q) begin
               stat_d  = 1'b0;
               state_d = S_STAT;
            end else if (cnt_q != 8'd0) begin
               cnt_d   = cnt_q - 8'd1;
               state_d = S_GET;
               start   = rd_q;
               xbyte   = FILL_BYTE;
            end
         end
         S_STAT: begin
            tx_data_d = err_q;
            txreq_d   = 1'b1;
            state_d   = S_URQ;
         end
         default: state_d = S_IDLE;
      endcase
      if (start) begin
         to_agent_d = xbyte;
         hex_d      = {xbyte, hex_q[7:0]};
         treq_d     = 1'b1;
         state_d    = S_SRQ;
      end
      // bytes arriving mid-transfer or mid-status are dropped and counted as errors
      if (rx_ready && state_q inside {S_SRQ, S_SGT, S_URQ, S_STAT}) err_d = err_inc;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         cnt_q      <= '0;
         lo_q       <= '0;
         rd_q       <= 1'b0;
         stat_q     <= 1'b0;
         spi_div_q  <= '0;
         to_agent_q <= '0;
         tx_data_q  <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         treq_q     <= 1'b0;
         txreq_q    <= 1'b0;
         baud_q     <= 16'(DEFAULT_BAUD_DIV);
         hex_q      <= '0;
         cs_n_q     <= '1;
         cmd_cnt_q  <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cnt_q      <= cnt_d;
         lo_q       <= lo_d;
         rd_q       <= rd_d;
         stat_q     <= stat_d;
         spi_div_q  <= spi_div_d;
         to_agent_q <= to_agent_d;
         tx_data_q  <= tx_data_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         treq_q     <= treq_d;
         txreq_q    <= txreq_d;
         baud_q     <= baud_d;
         hex_q      <= hex_d;
         cs_n_q     <= cs_n_d;
         cmd_cnt_q  <= cmd_cnt_d;
         err_q      <= err_d;
      end
   end
   assign spi_clk_div  = spi_div_q;
   assign cpol         = cpol_q;
   assign cpha         = cpha_q;
   assign transfer_req = treq_q;
   assign to_agent     = to_agent_q;
   assign uart_clk_div = baud_q;
   assign tx_req       = txreq_q;
   assign tx_data      = tx_data_q;
   assign cs_n         = cs_n_q;
   assign led          = cmd_cnt_q;
   assign hex_data     = hex_q;
endmodule

// File: tb/tb_bridge_controller_multi.sv
// tb_bridge_controller_multi: randomized SPI agent / UART responders plus a command-level
// reference model of the bridge; each scenario task checks its own results.
module tb_bridge_controller_multi;
   localparam int         NUM_CS = 4;
   localparam logic [7:0] FILL   = 8'hFF;
   logic clk = 1'b0, rst = 1'b1;
   logic [7:0] spi_clk_div, to_agent, from_agent, tx_data, rx_data, led;
   logic cpol, cpha, transfer_req, transfer_ready, transfer_done, tx_req, tx_ready, rx_ready;
   logic [15:0] uart_clk_div, hex_data;
   logic [NUM_CS-1:0] cs_n;
   int tests = 0, fails = 0;
   logic [7:0] uart_log[$], spi_log[$], exp_uart[$], exp_spi[$], cq[$];
   logic [7:0] agent_key = 8'hFF;
   logic agent_busy = 1'b0, uart_busy = 1'b0, uart_hold = 1'b0;
   logic [7:0] m_spi, m_cmd, m_err, m_to, m_txd;
   logic m_cpol, m_cpha;
   logic [15:0] m_baud, m_hex;
   logic [NUM_CS-1:0] m_cs;

   bridge_controller_multi #(.NUM_CS(NUM_CS), .DEFAULT_BAUD_DIV(433), .FILL_BYTE(FILL)) dut (
      .clk(clk), .rst(rst), .spi_clk_div(spi_clk_div), .cpol(cpol), .cpha(cpha),
      .transfer_req(transfer_req), .transfer_ready(transfer_ready), .transfer_done(transfer_done),
      .to_agent(to_agent), .from_agent(from_agent), .uart_clk_div(uart_clk_div),
      .tx_req(tx_req), .tx_data(tx_data), .rx_data(rx_data), .tx_ready(tx_ready),
      .rx_ready(rx_ready), .cs_n(cs_n), .led(led), .hex_data(hex_data)
   );

   always #5 clk = ~clk;

   initial begin : agent
      logic [7:0] b;
      transfer_ready = 1'b0;
      transfer_done  = 1'b0;
      from_agent     = 8'h00;
      forever begin
         @(negedge clk);
         if (transfer_req && !rst) begin
            agent_busy = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b = to_agent;
            transfer_ready = 1'b1;
            @(negedge clk);
            transfer_ready = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            from_agent    = b ^ agent_key;
            transfer_done = 1'b1;
            @(negedge clk);
            transfer_done = 1'b0;
            spi_log.push_back(b);
            agent_busy = 1'b0;
         end
      end
   end

   initial begin : uart
      tx_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_req && !uart_hold) begin
            uart_busy = 1'b1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            uart_log.push_back(tx_data);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready  = 1'b0;
            uart_busy = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired, simulation did not finish");
      $fatal(1);
   end

   task automatic wait_idle();
      int quiet = 0;
      int n = 0;
      while (quiet < 3 && n < 300) begin
         @(negedge clk);
         n++;
         quiet = (transfer_req || tx_req || agent_busy || uart_busy) ? 0 : quiet + 1;
      end
      if (quiet < 3) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout busy after %0d cycles, required idle bus", n);
      end
   endtask

   task automatic send_raw(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic bump_err();
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
   endtask

   task automatic xfer(input logic [7:0] d);
      exp_spi.push_back(d);
      exp_uart.push_back(d ^ agent_key);
      m_hex = {d, d ^ agent_key};
      m_to  = d;
   endtask

   task automatic model_reset();
      m_spi = 0; m_cmd = 0; m_err = 0; m_to = 0; m_txd = 0;
      m_cpol = 0; m_cpha = 0; m_baud = 16'd433; m_hex = 0; m_cs = '1;
      uart_log.delete(); spi_log.delete(); exp_uart.delete(); exp_spi.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_idle();
      model_reset();
   endtask

   // Apply the whole command in cq to the model, then deliver it byte by byte.
   task automatic run();
      logic [7:0] op;
      op    = cq[0];
      m_cmd = m_cmd + 8'd1;
      if (op == 8'h01) exp_uart.push_back(cq[1]);
      else if (op == 8'h02) m_spi = cq[1];
      else if (op == 8'h03) begin m_cpha = cq[1][0]; m_cpol = cq[1][1]; end
      else if (op == 8'h04) m_baud = {cq[2], cq[1]};
      else if (op == 8'h05) begin
         m_cs = '1;
         if (cq[1][7] && int'(cq[1][6:0]) < NUM_CS) begin
            for (int i = 0; i < NUM_CS; i++) if (i == int'(cq[1][6:0])) m_cs[i] = 1'b0;
         end else if (cq[1][7]) bump_err();
      end
      else if (op == 8'h06) xfer(cq[1]);
      else if (op == 8'h07) for (int i = 0; i <= int'(cq[1]); i++) xfer(cq[2+i]);
      else if (op == 8'h08) for (int i = 0; i <= int'(cq[1]); i++) xfer(FILL);
      else if (op == 8'h09) begin exp_uart.push_back(m_cmd); exp_uart.push_back(m_err); end
      else if (op != 8'h00) bump_err();
      if (exp_uart.size() > 0) m_txd = exp_uart[$];
      foreach (cq[i]) begin
         send_raw(cq[i]);
         wait_idle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      tests++;
      if ({spi_clk_div, cpol, cpha, transfer_req, to_agent, tx_req, tx_data, hex_data} !== 44'd0) begin
         fails++;
         $display("FAIL reset_zero got %h want 0", {spi_clk_div, cpol, cpha, transfer_req, to_agent, tx_req, tx_data, hex_data});
      end
      tests++;
      if (uart_clk_div !== 16'd433) begin fails++; $display("FAIL reset_baud got %0d want 433", uart_clk_div); end
      tests++;
      if (cs_n !== 4'hF) begin fails++; $display("FAIL reset_cs got %b want 1111", cs_n); end
      tests++;
      if (led !== 8'h00) begin fails++; $display("FAIL reset_led got %h want 00", led); end
      do_reset();
   endtask

   task automatic test_test_baud();
      cq = '{8'h01, 8'hA5};
      run();
      tests++;
      if (uart_log.size() != 1 || uart_log[0] !== 8'hA5) begin
         fails++;
         $display("FAIL echo got %0d bytes first %h want 1 byte A5", uart_log.size(), uart_log[0]);
      end
      tests++;
      if (led !== 8'd1) begin fails++; $display("FAIL echo_led got %0d want 1", led); end
      cq = '{8'h04, 8'h1B, 8'h00};
      run();
      tests++;
      if (uart_clk_div !== 16'h001B) begin fails++; $display("FAIL baud got %h want 001B", uart_clk_div); end
      tests++;
      if (led !== 8'd2 || uart_log.size() != 1) begin
         fails++;
         $display("FAIL baud_led got led %0d uart %0d want led 2 uart 1", led, uart_log.size());
      end
      uart_log.delete();
      exp_uart.delete();
   endtask

   task automatic test_chipsel();
      cq = '{8'h05, 8'h82};
      run();
      tests++;
      if (cs_n !== 4'b1011) begin fails++; $display("FAIL cs_sel2 got %b want 1011", cs_n); end
      cq = '{8'h05, 8'h87};
      run();
      tests++;
      if (cs_n !== 4'hF) begin fails++; $display("FAIL cs_oor got %b want 1111", cs_n); end
      cq = '{8'h05, 8'h00};
      run();
      tests++;
      if (cs_n !== 4'hF) begin fails++; $display("FAIL cs_off got %b want 1111", cs_n); end
      cq = '{8'h09};
      run();
      tests++;
      if (uart_log.size() != 2 || uart_log[0] !== 8'd6 || uart_log[1] !== 8'd1) begin
         fails++;
         $display("FAIL cs_status got n=%0d %h %h want n=2 06 01", uart_log.size(), uart_log[0], uart_log[1]);
      end
      uart_log.delete();
      exp_uart.delete();
   endtask

   task automatic test_burst();
      agent_key = 8'hFF;
      cq = '{8'h05, 8'h81};
      run();
      cq = '{8'h07, 8'h02, 8'h11, 8'h22, 8'h33};
      run();
      tests++;
      if (uart_log.size() != 3) begin
         fails++;
         $display("FAIL burst_uart_n got %0d want 3", uart_log.size());
      end else foreach (exp_uart[i]) begin
         tests++;
         if (uart_log[i] !== exp_uart[i]) begin
            fails++;
            $display("FAIL burst_uart[%0d] got %h want %h", i, uart_log[i], exp_uart[i]);
         end
      end
      tests++;
      if (spi_log.size() != 3 || spi_log[0] !== 8'h11 || spi_log[2] !== 8'h33) begin
         fails++;
         $display("FAIL burst_spi got n=%0d %h..%h want n=3 11..33", spi_log.size(), spi_log[0], spi_log[2]);
      end
      tests++;
      if (hex_data !== 16'h33CC) begin fails++; $display("FAIL burst_hex got %h want 33CC", hex_data); end
      tests++;
      if (cs_n !== 4'b1101) begin fails++; $display("FAIL burst_cs got %b want 1101", cs_n); end
      uart_log.delete(); exp_uart.delete(); spi_log.delete(); exp_spi.delete();
   endtask

   task automatic test_read();
      agent_key = 8'hA5;
      cq = '{8'h08, 8'h00};
      run();
      tests++;
      if (spi_log.size() != 1 || spi_log[0] !== 8'hFF) begin
         fails++;
         $display("FAIL read_spi got n=%0d %h want n=1 FF", spi_log.size(), spi_log[0]);
      end
      tests++;
      if (uart_log.size() != 1 || uart_log[0] !== 8'h5A) begin
         fails++;
         $display("FAIL read_uart got n=%0d %h want n=1 5A", uart_log.size(), uart_log[0]);
      end
      cq = '{8'h01, 8'h77};
      run();
      tests++;
      if (uart_log.size() != 2 || uart_log[1] !== 8'h77) begin
         fails++;
         $display("FAIL read_then_idle got n=%0d %h want n=2 77", uart_log.size(), uart_log[1]);
      end
      uart_log.delete(); exp_uart.delete(); spi_log.delete(); exp_spi.delete();
   endtask

   task automatic test_status();
      do_reset();
      cq = '{8'h3C};
      run();
      cq = '{8'h09};
      run();
      tests++;
      if (uart_log.size() != 2 || uart_log[0] !== 8'h02 || uart_log[1] !== 8'h01) begin
         fails++;
         $display("FAIL status got n=%0d %h %h want n=2 02 01", uart_log.size(), uart_log[0], uart_log[1]);
      end
      uart_log.delete();
      exp_uart.delete();
   endtask

   task automatic test_busy();
      agent_key = 8'h0F;
      uart_hold = 1'b1;
      send_raw(8'h06);
      wait_idle();
      send_raw(8'h42);
      m_cmd = m_cmd + 8'd1;
      xfer(8'h42);
      for (int n = 0; n < 100 && !tx_req; n++) @(negedge clk);
      tests++;
      if (!tx_req) begin fails++; $display("FAIL busy_txreq got 0 want 1"); end
      send_raw(8'h99);
      bump_err();
      tests++;
      if (led !== m_cmd) begin fails++; $display("FAIL busy_led got %0d want %0d", led, m_cmd); end
      uart_hold = 1'b0;
      wait_idle();
      cq = '{8'h09};
      run();
      tests++;
      if (uart_log.size() != 3) begin
         fails++;
         $display("FAIL busy_uart_n got %0d want 3", uart_log.size());
      end else foreach (exp_uart[i]) begin
         tests++;
         if (uart_log[i] !== exp_uart[i]) begin
            fails++;
            $display("FAIL busy_uart[%0d] got %h want %h", i, uart_log[i], exp_uart[i]);
         end
      end
      uart_log.delete(); exp_uart.delete(); spi_log.delete(); exp_spi.delete();
   endtask

   task automatic test_wrap_sat();
      do_reset();
      for (int k = 0; k < 256; k++) begin
         cq = '{8'($urandom_range(10, 255))};
         run();
      end
      tests++;
      if (led !== 8'h00) begin fails++; $display("FAIL wrap_led got %h want 00", led); end
      cq = '{8'h09};
      run();
      tests++;
      if (uart_log.size() != 2 || uart_log[0] !== 8'h01 || uart_log[1] !== 8'hFF) begin
         fails++;
         $display("FAIL sat_status got n=%0d %h %h want n=2 01 FF", uart_log.size(), uart_log[0], uart_log[1]);
      end
      uart_log.delete();
      exp_uart.delete();
   endtask

   task automatic test_random();
      agent_key = 8'($urandom);
      for (int k = 0; k < 40; k++) begin
         int op;
         op = $urandom_range(0, 10);
         cq.delete();
         cq.push_back(op == 10 ? 8'($urandom_range(10, 255)) : 8'(op));
         if (op inside {1, 2, 3, 5, 6}) cq.push_back(8'($urandom));
         else if (op == 4) begin cq.push_back(8'($urandom)); cq.push_back(8'($urandom)); end
         else if (op == 7 || op == 8) begin
            int len;
            len = $urandom_range(0, 3);
            cq.push_back(8'(len));
            if (op == 7) for (int j = 0; j <= len; j++) cq.push_back(8'($urandom));
         end
         if (op == 5 && $urandom_range(0, 1) == 1) cq[1] = {1'b1, 7'($urandom_range(0, 5))};
         run();
      end
      tests++;
      if (uart_log.size() != exp_uart.size()) begin
         fails++;
         $display("FAIL rand_uart_n got %0d want %0d", uart_log.size(), exp_uart.size());
      end else foreach (exp_uart[i]) begin
         tests++;
         if (uart_log[i] !== exp_uart[i]) begin
            fails++;
            $display("FAIL rand_uart[%0d] got %h want %h", i, uart_log[i], exp_uart[i]);
         end
      end
      tests++;
      if (spi_log.size() != exp_spi.size()) begin
         fails++;
         $display("FAIL rand_spi_n got %0d want %0d", spi_log.size(), exp_spi.size());
      end else foreach (exp_spi[i]) begin
         tests++;
         if (spi_log[i] !== exp_spi[i]) begin
            fails++;
            $display("FAIL rand_spi[%0d] got %h want %h", i, spi_log[i], exp_spi[i]);
         end
      end
      tests++;
      if ({spi_clk_div, cpol, cpha, uart_clk_div, cs_n} !== {m_spi, m_cpol, m_cpha, m_baud, m_cs}) begin
         fails++;
         $display("FAIL rand_cfg got %h want %h", {spi_clk_div, cpol, cpha, uart_clk_div, cs_n}, {m_spi, m_cpol, m_cpha, m_baud, m_cs});
      end
      tests++;
      if ({led, hex_data, to_agent, tx_data} !== {m_cmd, m_hex, m_to, m_txd}) begin
         fails++;
         $display("FAIL rand_out got %h want %h", {led, hex_data, to_agent, tx_data}, {m_cmd, m_hex, m_to, m_txd});
      end
      uart_log.delete(); exp_uart.delete(); spi_log.delete(); exp_spi.delete();
   endtask

   task automatic test_reset_mid();
      agent_key = 8'hFF;
      cq = '{8'h05, 8'h80};
      run();
      tests++;
      if (cs_n !== 4'b1110) begin fails++; $display("FAIL mid_cs_set got %b want 1110", cs_n); end
      send_raw(8'h07);
      wait_idle();
      send_raw(8'h01);
      wait_idle();
      send_raw(8'h55);
      for (int n = 0; n < 100 && !(agent_busy && !transfer_req); n++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({transfer_req, tx_req, cs_n} !== {2'b00, 4'hF}) begin
         fails++;
         $display("FAIL mid_rst_sgt got req %b tx %b cs %b want 0 0 1111", transfer_req, tx_req, cs_n);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_idle();
      model_reset();
      uart_hold = 1'b1;
      send_raw(8'h01);
      wait_idle();
      send_raw(8'hC3);
      for (int n = 0; n < 100 && !tx_req; n++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      tests++;
      if (tx_req !== 1'b0 || led !== 8'h00) begin
         fails++;
         $display("FAIL mid_rst_urq got tx %b led %h want 0 00", tx_req, led);
      end
      @(negedge clk);
      rst = 1'b0;
      uart_hold = 1'b0;
      wait_idle();
      model_reset();
      cq = '{8'h01, 8'h3C};
      run();
      tests++;
      if (uart_log.size() != 1 || uart_log[0] !== 8'h3C || led !== 8'd1) begin
         fails++;
         $display("FAIL mid_recover got n=%0d %h led %0d want n=1 3C led 1", uart_log.size(), uart_log[0], led);
      end
   endtask

   initial begin
      test_reset();
      test_test_baud();
      test_chipsel();
      test_burst();
      test_read();
      test_status();
      test_busy();
      test_wrap_sat();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
